// File: rtl/readout_pkg.sv
// ----------------------------------------------------------------------------
// readout_pkg
// Shared definitions for the row-readout sequencer:
//   READOUT  - main-FSM code during which the sequencer may run
//   state_t  - sequencer state encoding (also exported on o_State for debug)
// ----------------------------------------------------------------------------
package readout_pkg;

  localparam logic [1:0] READOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/readout_sequencer_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Up-counter that measures the length of one sequencer phase.
//   i_Clock   - clock, rising edge
//   i_Reset_n - asynchronous active-low reset
//   i_Load    - phase length in cycles (>= 1)
//   i_Clear   - restart the count at 0 on the next edge
//   o_Expire  - high during the last cycle of the phase (count == i_Load-1)
// The owner clears the timer on every phase change, and each counting phase
// exits at expiry, so the count never wraps.
// ----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic [CNT_W-1:0] i_Load,
  input  logic             i_Clear,
  output logic             o_Expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;

  assign last_cnt = i_Load - {{(CNT_W-1){1'b0}}, 1'b1};
  assign o_Expire = (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (i_Clear) cnt_d = '0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/readout_sequencer.sv
// ----------------------------------------------------------------------------
// readout_sequencer
// Walks NUM_ROWS rows once per entry of the main FSM into READOUT. Per row:
// NRE low for SETTLE_CYCLES, one ADC convert strobe, wait for ADC done,
// HOLD_CYCLES more NRE low, then GAP_CYCLES with NRE high.
// Ports:
//   i_Clock, i_Reset_n (async active-low)
//   i_Main_FSM  - main FSM state, sequencer runs while it equals READOUT
//   i_ADC_Done  - ADC conversion complete (pulse or level)
//   o_NRE       - row enable, active low
//   o_ADC_Conv  - one-cycle convert strobe per row
//   o_Row       - current row index
//   o_State     - sequencer state (debug)
//   o_Busy      - high in SETTLE/CONVERT/HOLD/GAP
//   o_Done      - one-cycle pulse on entry to DONE
//   o_Error     - sticky ADC-timeout flag
// Optional feature macro: READOUT_TIMEOUT_EN enables the ADC wait limit
// (TIMEOUT_CYCLES); without it CONVERT waits indefinitely and o_Error is 0.
// All outputs are registered.
// ----------------------------------------------------------------------------
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int NUM_ROWS       = 2,
  parameter int CNT_W          = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic [1:0]       i_Main_FSM,
  input  logic             i_ADC_Done,
  output logic             o_NRE,
  output logic             o_ADC_Conv,
  output logic [ROW_W-1:0] o_Row,
  output logic [2:0]       o_State,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Error
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             nre_q, nre_d;
  logic             conv_q, conv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_clr, tmr_exp;
  logic [CNT_W-1:0] tmr_len;
  logic             in_ro, busy_st;
`ifdef READOUT_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  assign in_ro   = (i_Main_FSM == READOUT);
  assign busy_st = (state_q == ST_SETTLE) || (state_q == ST_CONVERT) ||
                   (state_q == ST_HOLD)   || (state_q == ST_GAP);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Load    (tmr_len),
    .i_Clear   (tmr_clr),
    .o_Expire  (tmr_exp)
  );

  // One timer serves every timed phase; its length follows the current state.
  always_comb begin
    case (state_q)
      ST_HOLD:    tmr_len = CNT_W'(HOLD_CYCLES);
      ST_GAP:     tmr_len = CNT_W'(GAP_CYCLES);
      ST_CONVERT: tmr_len = CNT_W'(TIMEOUT_CYCLES);
      default:    tmr_len = CNT_W'(SETTLE_CYCLES);
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tmr_clr = 1'b1;
`ifdef READOUT_TIMEOUT_EN
    err_d   = err_q;
`endif
    if (busy_st && !in_ro) begin
      // Leaving READOUT mid-run aborts without a Done pulse.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_ro) state_d = ST_SETTLE;
        ST_SETTLE: begin
          tmr_clr = 1'b0;
          if (tmr_exp) state_d = ST_CONVERT;
        end
        ST_CONVERT: begin
          // conv_q marks the strobe cycle, in which done is not yet trusted.
          if (!conv_q && i_ADC_Done) begin
            state_d = ST_HOLD;
          end
`ifdef READOUT_TIMEOUT_EN
          else begin
            tmr_clr = 1'b0;
            if (tmr_exp) begin
              state_d = ST_GAP;
              err_d   = 1'b1;
            end
          end
`endif
        end
        ST_HOLD: begin
          tmr_clr = 1'b0;
          if (tmr_exp) state_d = ST_GAP;
        end
        ST_GAP: begin
          tmr_clr = 1'b0;
          if (tmr_exp) begin
            if (row_q == LAST_ROW) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SETTLE;
              row_d   = row_q + ROW_W'(1);
            end
          end
        end
        ST_DONE: if (!in_ro) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Every phase starts counting from zero.
    if (state_d != state_q) tmr_clr = 1'b1;
    if (state_d == ST_IDLE) row_d = '0;
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    nre_d  = !((state_d == ST_SETTLE) || (state_d == ST_CONVERT) || (state_d == ST_HOLD));
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CONVERT) ||
             (state_d == ST_HOLD)   || (state_d == ST_GAP);
    conv_d = (state_q == ST_SETTLE) && (state_d == ST_CONVERT);
    done_d = (state_q == ST_GAP) && (state_d == ST_DONE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      nre_q   <= 1'b1;
      conv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      nre_q   <= nre_d;
      conv_q  <= conv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef READOUT_TIMEOUT_EN
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) err_q <= 1'b0;
    else            err_q <= err_d;
  end
  assign o_Error = err_q;
`else
  assign o_Error = 1'b0;
`endif

  assign o_NRE      = nre_q;
  assign o_ADC_Conv = conv_q;
  assign o_Row      = row_q;
  assign o_State    = state_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;

endmodule
